// File: rtl/alu_exec_pkg.sv
// Shared types for the execute sequencer: ALU op encoding, sequencer FSM states
// and the default number of implemented registers.
package alu_exec_pkg;

    localparam int unsigned NumRegsDefault = 3;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpNot = 3'b110,
        OpLdi = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StExe,
        StWb,
        StErr
    } exec_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU used by the execute sequencer.
// Ports:
//   op     - operation select (alu_op_e)
//   a, b   - operands; imm - immediate for LDI
//   result - operation result, modulo 2^DATA_W
//   c      - carry-out (ADD), borrow (SUB), shifted-out bit (SHL), else 0
//   z      - result is zero
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   imm,
    output logic [DATA_W-1:0]   result,
    output logic                c,
    output logic                z
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        c      = 1'b0;
        unique case (op)
            OpAdd: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
            end
            OpSub: begin
                result = a - b;
                c      = (a < b);
            end
            OpAnd: result = a & b;
            OpOr:  result = a | b;
            OpXor: result = a ^ b;
            OpShl: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            OpNot: result = ~a;
            OpLdi: result = imm;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer; sole master of the register file's single port.
// Each accepted op runs IDLE -> RDA -> RDB -> EXE -> WB, or IDLE -> ERR when any
// register address is out of range. All rf_*, done, err and flag outputs are
// registered; req_ready is decoded from state.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req_valid/ready    - request handshake (ready only in IDLE)
//   req_op/rs1/rs2/rd  - operation, sources A/B, destination
//   req_imm            - immediate for LDI
//   rf_addr/wdata/write- register file port
//   rf_rdata           - register file read data, one cycle after rf_addr
//   done, err          - completion pulse, with err for illegal addresses
//   flag_z, flag_c     - zero/carry of the last completed legal op
module alu_exec_seq
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = NumRegsDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_imm,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [ADDR_W-1:0] RegLimit = ADDR_W'(NUM_REGS);

    exec_state_e       state_q;
    alu_op_e           op_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              res_c_q;
    logic              res_z_q;

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c;
    logic              alu_z;
    logic              req_legal;

    assign req_ready = (state_q == StIdle);
    assign req_legal = (req_rs1 < RegLimit) && (req_rs2 < RegLimit) && (req_rd < RegLimit);

    // B arrives on rf_rdata during EXE and is only captured at the end of it.
    assign alu_b = (state_q == StExe) ? rf_rdata : op_b_q;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (op_a_q),
        .b      (alu_b),
        .imm    (imm_q),
        .result (alu_result),
        .c      (alu_c),
        .z      (alu_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_c_q  <= 1'b0;
            res_z_q  <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rf_write <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q  <= alu_op_e'(req_op);
                        rs2_q <= req_rs2;
                        rd_q  <= req_rd;
                        imm_q <= req_imm;
                        if (req_legal) begin
                            state_q <= StRdA;
                            rf_addr <= req_rs1;
                        end else begin
                            state_q <= StErr;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end
                    end
                end
                StRdA: begin
                    state_q <= StRdB;
                    rf_addr <= rs2_q;
                end
                StRdB: begin
                    // rf_rdata now carries rs1, addressed during RDA.
                    op_a_q  <= rf_rdata;
                    state_q <= StExe;
                end
                StExe: begin
                    op_b_q   <= rf_rdata;
                    res_c_q  <= alu_c;
                    res_z_q  <= alu_z;
                    rf_wdata <= alu_result;
                    rf_addr  <= rd_q;
                    rf_write <= 1'b1;
                    done     <= 1'b1;
                    state_q  <= StWb;
                end
                StWb: begin
                    flag_z   <= res_z_q;
                    flag_c   <= res_c_q;
                    rf_addr  <= '0;
                    rf_write <= 1'b0;
                    done     <= 1'b0;
                    state_q  <= StIdle;
                end
                StErr: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: a register file model with registered read
// sits behind the DUT, and a reference register array plus arithmetic model predicts
// every write, completion and flag value.
module tb_alu_exec_seq;

    localparam int unsigned DataW   = 8;
    localparam int unsigned AddrW   = 4;
    localparam int unsigned NumRegs = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [AddrW-1:0] req_rs1;
    logic [AddrW-1:0] req_rs2;
    logic [AddrW-1:0] req_rd;
    logic [DataW-1:0] req_imm;
    logic [AddrW-1:0] rf_addr;
    logic [DataW-1:0] rf_wdata;
    logic             rf_write;
    logic [DataW-1:0] rf_rdata;
    logic             done;
    logic             err;
    logic             flag_z;
    logic             flag_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int write_cnt = 0;
    int acc_cyc = 0;

    logic [DataW-1:0] rf_mem [NumRegs] = '{8'h00, 8'h00, 8'h00};
    logic [DataW-1:0] ref_regs [NumRegs];
    logic             ref_z;
    logic             ref_c;

    always #5 clk = ~clk;

    alu_exec_seq #(
        .DATA_W   (DataW),
        .ADDR_W   (AddrW),
        .NUM_REGS (NumRegs)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_write  (rf_write),
        .rf_rdata  (rf_rdata),
        .done      (done),
        .err       (err),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    // Register file: write and registered read on the same port.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write) begin
            write_cnt <= write_cnt + 1;
            if (int'(rf_addr) < NumRegs) rf_mem[int'(rf_addr)] <= rf_wdata;
        end
        rf_rdata <= (int'(rf_addr) < NumRegs) ? rf_mem[int'(rf_addr)] : 8'h00;
    end

    // Reference arithmetic straight from the op definitions.
    function automatic void alu_ref(input int op, input int a, input int b, input int imm,
                                    output int res, output bit c);
        c = 1'b0;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b) > 255; end
            1: begin res = (a - b + 256) % 256; c = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 256; c = (a >= 128); end
            6: res = 255 - a;
            default: res = imm;
        endcase
    endfunction

    task automatic scramble_fields();
        req_op  = 3'($urandom);
        req_rs1 = 4'($urandom);
        req_rs2 = 4'($urandom);
        req_rd  = 4'($urandom);
        req_imm = 8'($urandom);
    endtask

    // Starts at a negedge with the DUT idle, ends at the first negedge where it is idle again.
    task automatic run_op(input int op, input int rs1, input int rs2, input int rd,
                          input int imm, input bit hold);
        bit               legal;
        int               a;
        int               b;
        int               res;
        bit               c;
        bit               z;
        int               w0;
        logic [AddrW-1:0] exp_addr [5];
        logic [7:0]       got_st;
        logic [7:0]       exp_st;

        legal = (rs1 < NumRegs) && (rs2 < NumRegs) && (rd < NumRegs);
        a = legal ? int'(ref_regs[rs1]) : 0;
        b = legal ? int'(ref_regs[rs2]) : 0;
        alu_ref(op, a, b, imm, res, c);
        z = (res == 0);
        w0 = write_cnt;

        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_before_accept: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_rs1   = 4'(rs1);
        req_rs2   = 4'(rs2);
        req_rd    = 4'(rd);
        req_imm   = 8'(imm);
        @(posedge clk);

        if (legal) begin
            exp_addr = '{4'd0, 4'(rs1), 4'(rs2), 4'(rs2), 4'(rd)};
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 1) acc_cyc = cyc;
                if (!hold) req_valid = 1'b0;
                scramble_fields();
                got_st = {rf_write, done, err, req_ready, rf_addr};
                exp_st = {(k == 4), (k == 4), 1'b0, 1'b0, exp_addr[k]};
                n_checks++;
                if (got_st !== exp_st) begin
                    n_errors++;
                    $display("FAIL seq_status op=%0d cycle=%0d {wr,done,err,rdy,addr}: got %h expected %h",
                             op, k, got_st, exp_st);
                end
                if (k == 4) begin
                    n_checks++;
                    if (rf_wdata !== 8'(res)) begin
                        n_errors++;
                        $display("FAIL wb_data op=%0d a=%h b=%h: got %h expected %h",
                                 op, a, b, rf_wdata, 8'(res));
                    end
                end
            end
            @(negedge clk);
            got_st = {rf_write, done, err, req_ready, rf_addr};
            n_checks++;
            if (got_st !== 8'h10) begin
                n_errors++;
                $display("FAIL idle_status {wr,done,err,rdy,addr}: got %h expected 10", got_st);
            end
            n_checks++;
            if ({flag_z, flag_c} !== {z, c}) begin
                n_errors++;
                $display("FAIL flags op=%0d {z,c}: got %b%b expected %b%b", op, flag_z, flag_c, z, c);
            end
            n_checks++;
            if (rf_mem[rd] !== 8'(res) || write_cnt != w0 + 1) begin
                n_errors++;
                $display("FAIL reg_commit r%0d: got %h (writes %0d) expected %h (writes %0d)",
                         rd, rf_mem[rd], write_cnt - w0, 8'(res), 1);
            end
            ref_regs[rd] = 8'(res);
            ref_z = z;
            ref_c = c;
        end else begin
            @(negedge clk);
            acc_cyc = cyc;
            if (!hold) req_valid = 1'b0;
            scramble_fields();
            got_st = {rf_write, done, err, req_ready, rf_addr};
            n_checks++;
            if (got_st !== 8'h60) begin
                n_errors++;
                $display("FAIL err_status {wr,done,err,rdy,addr}: got %h expected 60", got_st);
            end
            @(negedge clk);
            got_st = {rf_write, done, err, req_ready, rf_addr};
            n_checks++;
            if (got_st !== 8'h10) begin
                n_errors++;
                $display("FAIL err_idle {wr,done,err,rdy,addr}: got %h expected 10", got_st);
            end
            n_checks++;
            if ({flag_z, flag_c} !== {ref_z, ref_c} || write_cnt != w0) begin
                n_errors++;
                $display("FAIL err_no_effect {z,c,writes}: got %b%b %0d expected %b%b 0",
                         flag_z, flag_c, write_cnt - w0, ref_z, ref_c);
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1;
        req_valid = 1'b0;
        scramble_fields();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got = {req_ready, rf_write, done, err, flag_z, flag_c, rf_addr};
        n_checks++;
        if (got !== 10'h200 || rf_wdata !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_values {rdy,wr,done,err,z,c,addr} wdata: got %h %h expected 200 00",
                     got, rf_wdata);
        end
        for (int i = 0; i < NumRegs; i++) ref_regs[i] = 8'h00;
        ref_z = 1'b0;
        ref_c = 1'b0;
    endtask

    task automatic test_add_basic();
        run_op(7, 0, 0, 1, 8'h7F, 1'b0);
        run_op(7, 0, 0, 2, 8'h01, 1'b0);
        run_op(0, 1, 2, 0, 0, 1'b0);
        n_checks++;
        if (rf_mem[0] !== 8'h80 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            n_errors++;
            $display("FAIL add_basic r0,z,c: got %h %b %b expected 80 0 0", rf_mem[0], flag_z, flag_c);
        end
    endtask

    task automatic test_carry_borrow();
        run_op(7, 0, 0, 1, 8'hFF, 1'b0);
        run_op(7, 0, 0, 2, 8'h01, 1'b0);
        run_op(0, 1, 2, 0, 0, 1'b0);
        n_checks++;
        if (rf_mem[0] !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
            n_errors++;
            $display("FAIL add_carry r0,z,c: got %h %b %b expected 00 1 1", rf_mem[0], flag_z, flag_c);
        end
        run_op(1, 2, 1, 0, 0, 1'b0);
        n_checks++;
        if (rf_mem[0] !== 8'h02 || flag_c !== 1'b1) begin
            n_errors++;
            $display("FAIL sub_borrow r0,c: got %h %b expected 02 1", rf_mem[0], flag_c);
        end
    endtask

    task automatic test_shl_alias();
        run_op(7, 0, 0, 1, 8'h81, 1'b0);
        run_op(5, 1, 0, 1, 0, 1'b0);
        n_checks++;
        if (rf_mem[1] !== 8'h02 || flag_c !== 1'b1) begin
            n_errors++;
            $display("FAIL shl r1,c: got %h %b expected 02 1", rf_mem[1], flag_c);
        end
        run_op(0, 1, 1, 1, 0, 1'b0);
        n_checks++;
        if (rf_mem[1] !== 8'h04) begin
            n_errors++;
            $display("FAIL rd_eq_rs1 r1: got %h expected 04", rf_mem[1]);
        end
    endtask

    task automatic test_illegal();
        run_op(0, 0, 1, 3, 0, 1'b1);
        req_valid = 1'b0;
        run_op(7, 5, 0, 0, 8'h33, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        logic [9:0] got;
        int         w0;
        run_op(7, 0, 0, 1, 8'h10, 1'b0);
        run_op(7, 0, 0, 2, 8'h20, 1'b0);
        run_op(7, 0, 0, 0, 8'h55, 1'b0);
        w0 = write_cnt;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_rs1   = 4'd1;
        req_rs2   = 4'd2;
        req_rd    = 4'd0;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;  // cycle 3 is EXE
        @(negedge clk);
        rst = 1'b0;
        got = {req_ready, rf_write, done, err, flag_z, flag_c, rf_addr};
        n_checks++;
        if (got !== 10'h200 || rf_wdata !== 8'h00) begin
            n_errors++;
            $display("FAIL midop_reset {rdy,wr,done,err,z,c,addr} wdata: got %h %h expected 200 00",
                     got, rf_wdata);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (write_cnt != w0 || rf_mem[0] !== 8'h55) begin
            n_errors++;
            $display("FAIL midop_no_write writes,r0: got %0d %h expected 0 55", write_cnt - w0, rf_mem[0]);
        end
        ref_z = 1'b0;
        ref_c = 1'b0;
    endtask

    task automatic test_back_to_back();
        int prev;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 255)), 1'b1);
            if (i > 0) begin
                n_checks++;
                if (acc_cyc - prev != 5) begin
                    n_errors++;
                    $display("FAIL b2b_spacing: got %0d expected 5", acc_cyc - prev);
                end
            end
            prev = acc_cyc;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random();
        int rs [3];
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 3; j++)
                rs[j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                                     : int'($urandom_range(0, 2));
            run_op(int'($urandom_range(0, 7)), rs[0], rs[1], rs[2],
                   int'($urandom_range(0, 255)), 1'($urandom));
            req_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_borrow();
        test_shl_alias();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
